// File: rtl/ram_word_loader.sv
// ram_word_loader: builds words from a narrow switch bus, stores them in an
// internal sync RAM, reads single words back and sums the whole memory.
//   clk, reset      : system clock, async active-high reset
//   switches        : data chunk for load, address for read
//   key_n[3:0]      : active-low keys {sweep, read, write, load}
//   addr, stage     : RAM address pointer, staging register
//   rd_data         : last word read back
//   checksum        : result of last sweep
//   busy, done      : sweep in progress, sweep-complete pulse
module ram_word_loader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int IN_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   switches,
  input  logic [3:0]        key_n,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] stage,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] checksum,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_WAIT,
    S_SWEEP,
    S_SWEEP_TAIL,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        sync1_q, sync2_q;
  logic [3:0]        hist0_q, hist1_q;
  logic [3:0]        stb;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] stage_q, stage_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] ram_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we;
  logic [DATA_W-1:0] mem [DEPTH];

  // A strobe needs the two previous synchronised samples high, so a
  // held key fires once and a re-press needs a real release first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      hist0_q <= '1;
      hist1_q <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      hist0_q <= sync2_q;
      hist1_q <= hist0_q;
    end
  end

  assign stb = hist1_q & hist0_q & ~sync2_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rd_d    = rd_q;
    sum_d   = sum_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    we      = 1'b0;
    raddr   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        raddr = switches[ADDR_W-1:0];
        if (stb[0]) begin
          stage_d = (stage_q << IN_W) | DATA_W'(switches);
        end else if (stb[1]) begin
          we     = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
        end else if (stb[2]) begin
          addr_d  = switches[ADDR_W-1:0];
          state_d = S_READ_WAIT;
        end else if (stb[3]) begin
          // Word 0 is fetched on the strobe edge, so the
          // counter starts on the next address.
          raddr   = '0;
          cnt_d   = ADDR_W'(1);
          sum_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SWEEP;
        end
      end
      S_READ_WAIT: begin
        rd_d    = ram_q;
        state_d = S_IDLE;
      end
      S_SWEEP: begin
        sum_d = sum_q + ram_q;
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_SWEEP_TAIL;
        end
      end
      S_SWEEP_TAIL: begin
        sum_d   = sum_q + ram_q;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      stage_q <= '0;
      rd_q    <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rd_q    <= rd_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr_q] <= stage_q;
    end
    ram_q <= mem[raddr];
  end

  assign addr     = addr_q;
  assign stage    = stage_q;
  assign rd_data  = rd_q;
  assign checksum = sum_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ram_word_loader.sv
// tb_ram_word_loader: directed bench for ram_word_loader.
// Expected values are hand-computed constants.
module tb_ram_word_loader;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int IN_W   = 10;

  logic              clk;
  logic              reset;
  logic [IN_W-1:0]   switches;
  logic [3:0]        key_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] stage;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] checksum;
  logic              busy;
  logic              done;

  int n_chk;
  int n_fail;

  ram_word_loader #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .IN_W  (IN_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .switches(switches),
    .key_n   (key_n),
    .addr    (addr),
    .stage   (stage),
    .rd_data (rd_data),
    .checksum(checksum),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] mask,
                       input logic [IN_W-1:0] sw,
                       input int hold);
    @(negedge clk);
    switches = sw;
    key_n    = ~mask;
    repeat (hold) @(negedge clk);
    key_n = 4'hF;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_sweep(input bit inj_read,
                           output int bcnt,
                           output int dcnt,
                           output bit busy_at_done,
                           output logic [31:0] cks,
                           output bit ended);
    bcnt = 0;
    dcnt = 0;
    busy_at_done = 1'b0;
    cks = '0;
    ended = 1'b0;
    @(negedge clk);
    key_n = 4'b0111;
    @(negedge clk);
    @(negedge clk);
    key_n = 4'hF;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (inj_read && i == 5) begin
        switches = '0;
        key_n    = 4'b1011;
      end
      if (inj_read && i == 12) key_n = 4'hF;
      if (done) begin
        dcnt++;
        cks = checksum;
        busy_at_done = busy;
      end
      if (busy) begin
        bcnt++;
      end else if (bcnt > 0) begin
        ended = 1'b1;
        break;
      end
    end
    key_n = 4'hF;
    repeat (4) @(negedge clk);
  endtask

  int          bc;
  int          dc;
  bit          bd;
  bit          en;
  logic [31:0] ck;

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    switches = '0;
    key_n    = 4'hF;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_addr", 32'(addr), 32'h0);
      chk("rst_stage", stage, 32'h0);
      chk("rst_rd", rd_data, 32'h0);
      chk("rst_cks", checksum, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
    end

    press(4'b0001, 10'h3FF, 4);
    chk("load1", stage, 32'h0000_03FF);
    press(4'b0001, 10'h001, 4);
    press(4'b0001, 10'h2AA, 4);
    press(4'b0001, 10'h155, 4);
    chk("load4", stage, 32'hC01A_A955);
    chk("load_addr", 32'(addr), 32'h0);

    press(4'b0001, 10'h000, 4);
    press(4'b0001, 10'h000, 4);
    press(4'b0001, 10'h000, 4);
    press(4'b0001, 10'h005, 4);
    chk("stage5", stage, 32'h0000_0005);

    press(4'b0010, 10'h000, 4);
    chk("wr1_addr", 32'(addr), 32'h1);
    chk("wr1_stage", stage, 32'h0000_0005);
    for (int i = 1; i < 64; i++) press(4'b0010, 10'h000, 4);
    chk("wr64_addr", 32'(addr), 32'h0);

    // read latency: addr on strobe edge, rd_data one edge later
    @(negedge clk);
    switches = 10'h03F;
    key_n    = 4'b1011;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rd_addr", 32'(addr), 32'h3F);
    chk("rd_early", rd_data, 32'h0);
    @(negedge clk);
    chk("rd_data", rd_data, 32'h0000_0005);
    key_n = 4'hF;
    repeat (4) @(negedge clk);

    run_sweep(1'b0, bc, dc, bd, ck, en);
    chk("sw1_end", 32'(en), 32'h1);
    chk("sw1_busy", 32'(bc), 32'd65);
    chk("sw1_done", 32'(dc), 32'd1);
    chk("sw1_last", 32'(bd), 32'h1);
    chk("sw1_cks", ck, 32'h0000_0140);
    chk("sw1_addr", 32'(addr), 32'h3F);
    chk("sw1_rd", rd_data, 32'h0000_0005);

    run_sweep(1'b1, bc, dc, bd, ck, en);
    chk("sw2_busy", 32'(bc), 32'd65);
    chk("sw2_cks", ck, 32'h0000_0140);
    repeat (10) @(negedge clk);
    chk("lock_rd", rd_data, 32'h0000_0005);
    chk("lock_addr", 32'(addr), 32'h3F);
    chk("lock_stage", stage, 32'h0000_0005);

    press(4'b0011, 10'h123, 4);
    chk("prio_stage", stage, 32'h0000_1523);
    chk("prio_addr", 32'(addr), 32'h3F);

    press(4'b0001, 10'h001, 20);
    chk("hold_stage", stage, 32'h0054_8C01);

    @(negedge clk);
    key_n = 4'b0111;
    @(negedge clk);
    @(negedge clk);
    key_n = 4'hF;
    repeat (10) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_cks", checksum, 32'h0);
    chk("ab_done", 32'(done), 32'h0);
    chk("ab_addr", 32'(addr), 32'h0);
    chk("ab_stage", stage, 32'h0);
    chk("ab_rd", rd_data, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dc = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done || busy) dc++;
    end
    chk("ab_quiet", 32'(dc), 32'd0);

    run_sweep(1'b0, bc, dc, bd, ck, en);
    chk("sw3_busy", 32'(bc), 32'd65);
    chk("sw3_done", 32'(dc), 32'd1);
    chk("sw3_cks", ck, 32'h0000_0140);
    chk("sw3_addr", 32'(addr), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_word_loader.md
# ram_word_loader

Parametrised successor to the stage-1 control/datapath pair. It assembles DATA_W-bit words from a narrow switch bus, writes them into an internal DEPTH x DATA_W synchronous RAM (64 x 32 by default), reads back single words, and runs a full-memory checksum sweep. Key presses drive the sequencing. It sits under the board top, between CLOCK_50/SW/KEY and the display logic.

## Interface
- DATA_W, 32, RAM word width and staging register width
- DEPTH, 64, number of RAM words (power of two)
- ADDR_W, 6, address width, equal to log2(DEPTH)
- IN_W, 10, switch bus width; IN_W >= ADDR_W, IN_W <= DATA_W
- clk  in  1  single system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all registers
- switches  in  IN_W  data chunk or read address
- key_n  in  4  active-low pushbuttons: [0] load, [1] write, [2] read, [3] sweep
- addr  out  ADDR_W  current RAM address pointer
- stage  out  DATA_W  staging register contents
- rd_data  out  DATA_W  last word read from RAM
- checksum  out  DATA_W  result of last sweep
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse when a sweep completes

## Operation
- Key front end: each key_n bit passes through a 2-FF synchroniser. A falling edge of the synchronised value makes a one-cycle strobe. Priority when strobes coincide: load > write > read > sweep. Lower-priority strobes in that cycle are discarded.
- All strobes are ignored while busy=1 or while the FSM is outside IDLE.
- FSM states: IDLE, READ_WAIT, SWEEP, SWEEP_TAIL, DONE.
- IDLE + load: stage <= {stage[DATA_W-IN_W-1:0], switches}. This is a shift-in, keeping the low DATA_W bits. Stays in IDLE.
- IDLE + write: RAM[addr] <= stage, then addr <= addr+1, wrapping DEPTH-1 -> 0. stage is unchanged. Stays in IDLE.
- IDLE + read: addr <= switches[ADDR_W-1:0] and the RAM read is issued at that address. Go to READ_WAIT. Next cycle: rd_data <= RAM output, go to IDLE.
- IDLE + sweep: checksum <= 0, internal sweep counter <= 0, busy <= 1, go to SWEEP.
- SWEEP: issue a read at the counter each cycle and add the previous cycle's RAM output to checksum, modulo 2^DATA_W. When the counter reaches DEPTH-1, go to SWEEP_TAIL.
- SWEEP_TAIL: add the final word, go to DONE.
- DONE: done=1 for one cycle, busy <= 0, go to IDLE.
- A sweep does not modify addr, stage or rd_data.
- RAM: synchronous write, synchronous read with registered output and 1-cycle latency. Contents are not cleared by reset.

## Timing
- Reset values: addr=0, stage=0, rd_data=0, checksum=0, busy=0, done=0, FSM=IDLE, synchronisers=all-ones (released keys).
- Reset asserted mid-sweep or mid-read aborts at once. All outputs return to reset values; no partial checksum is retained.
- Key latency: call edge E1 the first rising edge that samples key_n low. The strobe is high in the cycle after edge E2, and the action's register update lands on edge E3.
- Write: RAM[addr] and addr+1 both update on the same edge.
- Read: addr updates on the strobe edge; rd_data is valid one edge later.
- Sweep: busy rises on the strobe edge and stays high for DEPTH+1 cycles. done pulses in the last busy cycle, and busy falls with it. checksum is final when done=1.
- A key held low produces exactly one strobe. A new strobe needs a release, seen as 2 synchronised-high samples, followed by a new press.

## Test plan
- Reset then idle: all outputs hold reset values for 20 cycles with key_n=4'hF.
- Shift-in, DATA_W=32, IN_W=10: load 0x3FF, 0x001, 0x2AA, 0x155 -> stage=0xC01AA955, addr=0.
- Write/wrap: stage=0x00000005, press write 64 times -> addr returns to 0 after the 64th; read with switches=0x03F -> rd_data=0x00000005.
- Sweep: after the previous case, press sweep -> busy high for 65 cycles, then done pulses with checksum=0x00000140; addr and rd_data unchanged.
- Priority/lockout: press load and write in the same cycle -> only load acts. Press read during a sweep -> ignored, and rd_data unchanged after done.
- Reset mid-sweep: assert reset 10 cycles into a sweep -> busy=0 and checksum=0 immediately, no done pulse; a following sweep gives 0x00000140.
